// File: rtl/rtc_bcd_timebase_if.sv
// Button inputs and BCD time outputs of the real-time clock timebase.
// master drives the buttons; slave is the timebase itself.
interface rtc_bcd_timebase_if;
  logic       set_btn;
  logic       inc_btn;
  logic [7:0] hr_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] mode;
  logic       sec_tick;
  logic       min_tick;

  modport master (
    output set_btn, inc_btn,
    input  hr_bcd, min_bcd, sec_bcd, mode, sec_tick, min_tick
  );

  modport slave (
    input  set_btn, inc_btn,
    output hr_bcd, min_bcd, sec_bcd, mode, sec_tick, min_tick
  );
endinterface

// File: rtl/rtc_bcd_timebase.sv
// Free-running 24-hour BCD real-time clock with a seconds prescaler and a
// two-button set mode (RUN -> SET_HR -> SET_MIN -> RUN).
module rtc_bcd_timebase #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned PRE_W    = 26
) (
  input  logic                clk,
  input  logic                rst,
  rtc_bcd_timebase_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PRE_W-1:0] r_pre;
  logic [7:0]       r_hr;
  logic [7:0]       r_min;
  logic [7:0]       r_sec;
  logic             r_sec_tick;
  logic             r_min_tick;
  logic             r_set_q;
  logic             r_inc_q;

  logic             w_set_rise;
  logic             w_inc_rise;
  logic             w_pre_run;
  logic             w_hr_inc;
  logic             w_min_inc;
  logic             w_tick;

  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9)
      r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd24_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign w_set_rise = bus.set_btn & ~r_set_q;
  assign w_inc_rise = bus.inc_btn & ~r_inc_q;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // A set rise pre-empts both an increment and a due seconds tick.
  always_comb begin
    w_state_nxt = r_state;
    w_pre_run   = 1'b0;
    w_hr_inc    = 1'b0;
    w_min_inc   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_set_rise) w_state_nxt = SET_HR;
        else            w_pre_run   = 1'b1;
      end
      SET_HR: begin
        if (w_set_rise)      w_state_nxt = SET_MIN;
        else if (w_inc_rise) w_hr_inc    = 1'b1;
      end
      SET_MIN: begin
        if (w_set_rise)      w_state_nxt = RUN;
        else if (w_inc_rise) w_min_inc   = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_tick = w_pre_run && (r_pre == PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre      <= '0;
      r_hr       <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      r_sec_tick <= 1'b0;
      r_min_tick <= 1'b0;
      r_set_q    <= 1'b0;
      r_inc_q    <= 1'b0;
    end else begin
      r_set_q    <= bus.set_btn;
      r_inc_q    <= bus.inc_btn;
      r_sec_tick <= w_tick;
      r_min_tick <= w_tick && (r_sec == 8'h59);

      if (!w_pre_run || w_tick) r_pre <= '0;
      else                      r_pre <= r_pre + PRE_W'(1);

      if (w_tick) begin
        r_sec <= bcd60_inc(r_sec);
        if (r_sec == 8'h59) begin
          r_min <= bcd60_inc(r_min);
          if (r_min == 8'h59) r_hr <= bcd24_inc(r_hr);
        end
      end

      if (w_hr_inc) r_hr <= bcd24_inc(r_hr);

      if (w_min_inc) begin
        r_min <= bcd60_inc(r_min);
        r_sec <= '0;
      end
    end
  end

  assign bus.hr_bcd   = r_hr;
  assign bus.min_bcd  = r_min;
  assign bus.sec_bcd  = r_sec;
  assign bus.mode     = r_state;
  assign bus.sec_tick = r_sec_tick;
  assign bus.min_tick = r_min_tick;

endmodule

// File: tb/tb_rtc_bcd_timebase.sv
// Directed bench for rtc_bcd_timebase with TICK_DIV=4: expected values are
// queued when stimulus is applied and popped when the DUT output is sampled.
module tb_rtc_bcd_timebase;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   n_sec;
  int   n_min;
  int   sec_base;
  int   min_base;

  string      tq[$];
  logic [7:0] vq[$];

  rtc_bcd_timebase_if bus ();

  rtc_bcd_timebase #(
    .TICK_DIV (4),
    .PRE_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.sec_tick === 1'b1) n_sec++;
    if (bus.min_tick === 1'b1) n_min++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic expect_v(input string tag, input logic [7:0] v);
    tq.push_back(tag);
    vq.push_back(v);
  endtask

  task automatic cmp(input logic [7:0] obs);
    string      t;
    logic [7:0] e;
    checks++;
    if (vq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      t = tq.pop_front();
      e = vq.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_set();
    bus.set_btn = 1'b1; step(1);
    bus.set_btn = 1'b0; step(1);
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      bus.inc_btn = 1'b1; step(1);
      bus.inc_btn = 1'b0; step(1);
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] h,
                            input logic [7:0] m, input logic [7:0] s);
    expect_v({tag, "_hr"}, h);  cmp(bus.hr_bcd);
    expect_v({tag, "_min"}, m); cmp(bus.min_bcd);
    expect_v({tag, "_sec"}, s); cmp(bus.sec_bcd);
  endtask

  task automatic check_mode(input string tag, input logic [1:0] m);
    expect_v({tag, "_mode"}, {6'd0, m});
    cmp({6'd0, bus.mode});
  endtask

  task automatic check_ticks(input string tag, input logic st, input logic mt);
    expect_v({tag, "_sec_tick"}, {7'd0, st}); cmp({7'd0, bus.sec_tick});
    expect_v({tag, "_min_tick"}, {7'd0, mt}); cmp({7'd0, bus.min_tick});
  endtask

  initial begin
    errors = 0; checks = 0; n_sec = 0; n_min = 0;
    rst = 1'b1; bus.set_btn = 1'b0; bus.inc_btn = 1'b0;

    // Reset and basic counting
    step(2);
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check_mode("reset", 2'b00);
    check_ticks("reset", 1'b0, 1'b0);
    rst = 1'b0;
    step(3);
    check_time("pre_first_tick", 8'h00, 8'h00, 8'h00);
    check_ticks("pre_first_tick", 1'b0, 1'b0);
    step(1);
    check_time("first_tick", 8'h00, 8'h00, 8'h01);
    check_ticks("first_tick", 1'b1, 1'b0);
    step(236);
    check_time("tick60", 8'h00, 8'h01, 8'h00);
    check_ticks("tick60", 1'b1, 1'b1);
    step(1);
    check_ticks("after_tick60", 1'b0, 1'b0);
    expect_v("sec_tick_count60", 8'd60); cmp(8'(n_sec));
    expect_v("min_tick_count60", 8'd1);  cmp(8'(n_min));

    // Set mode from a fresh reset with a few seconds elapsed
    rst = 1'b1; step(1); rst = 1'b0;
    step(12);
    check_time("pre_set", 8'h00, 8'h00, 8'h03);
    pulse_set();
    check_mode("enter_set_hr", 2'b01);
    sec_base = n_sec; min_base = n_min;
    pulse_inc(25);
    check_time("hr_x25", 8'h01, 8'h00, 8'h03);
    pulse_set();
    check_mode("enter_set_min", 2'b10);
    pulse_inc(1);
    check_time("min_first_inc", 8'h01, 8'h01, 8'h00);
    pulse_inc(60);
    check_time("min_x61", 8'h01, 8'h01, 8'h00);
    expect_v("no_sec_ticks_in_set", 8'd0); cmp(8'(n_sec - sec_base));
    expect_v("no_min_ticks_in_set", 8'd0); cmp(8'(n_min - min_base));
    pulse_set();
    check_mode("back_to_run", 2'b00);
    step(2);
    check_time("run_restart_pre", 8'h01, 8'h01, 8'h00);
    step(1);
    check_time("run_restart_tick", 8'h01, 8'h01, 8'h01);
    check_ticks("run_restart_tick", 1'b1, 1'b0);

    // Held increment button acts once
    pulse_set();
    pulse_inc(4);
    check_time("hr_05", 8'h05, 8'h01, 8'h01);
    bus.inc_btn = 1'b1; step(50);
    bus.inc_btn = 1'b0; step(1);
    check_time("held_inc", 8'h06, 8'h01, 8'h01);

    // set and inc rising together: set wins
    bus.set_btn = 1'b1; bus.inc_btn = 1'b1; step(1);
    check_mode("collide_set_inc", 2'b10);
    check_time("collide_set_inc", 8'h06, 8'h01, 8'h01);
    bus.set_btn = 1'b0; bus.inc_btn = 1'b0; step(1);

    // Program 23:59 then wrap the day
    pulse_inc(58);
    check_time("min_59", 8'h06, 8'h59, 8'h00);
    pulse_set();
    pulse_set();
    check_mode("reenter_set_hr", 2'b01);
    pulse_inc(17);
    check_time("hr_23", 8'h23, 8'h59, 8'h00);
    pulse_set();
    pulse_set();
    check_mode("run_2359", 2'b00);
    check_time("run_2359", 8'h23, 8'h59, 8'h00);
    step(235);
    check_time("tick59", 8'h23, 8'h59, 8'h59);
    check_ticks("tick59", 1'b1, 1'b0);
    step(4);
    check_time("day_wrap", 8'h00, 8'h00, 8'h00);
    check_ticks("day_wrap", 1'b1, 1'b1);

    // set rise when the prescaler is at its last count
    step(3);
    sec_base = n_sec;
    bus.set_btn = 1'b1; step(1);
    check_mode("collide_set_tick", 2'b01);
    check_time("collide_set_tick", 8'h00, 8'h00, 8'h00);
    check_ticks("collide_set_tick", 1'b0, 1'b0);
    bus.set_btn = 1'b0; step(1);
    expect_v("collide_no_tick_count", 8'd0); cmp(8'(n_sec - sec_base));

    // Reset in the middle of setting 14:37
    pulse_inc(14);
    pulse_set();
    pulse_inc(37);
    check_time("set_1437", 8'h14, 8'h37, 8'h00);
    rst = 1'b1; step(1);
    check_mode("reset_mid_set", 2'b00);
    check_time("reset_mid_set", 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    step(3);
    check_time("post_reset_pre", 8'h00, 8'h00, 8'h00);
    step(1);
    check_time("post_reset_tick", 8'h00, 8'h00, 8'h01);
    check_ticks("post_reset_tick", 1'b1, 1'b0);

    // inc in RUN is ignored
    pulse_inc(1);
    check_mode("inc_in_run", 2'b00);
    expect_v("inc_in_run_hr", 8'h00);  cmp(bus.hr_bcd);
    expect_v("inc_in_run_min", 8'h00); cmp(bus.min_bcd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_bcd_timebase.md
Name: rtc_bcd_timebase

Overview:
- Free-running 24-hour real-time clock; produces BCD hours/minutes/seconds.
- Upstream stage of the alarm compare/set block: hr_bcd and min_bcd drive its clock-hour and clock-minute inputs directly.
- Contains a seconds prescaler, cascaded BCD counters, and a three-state set-mode FSM driven by two push buttons.

Parameters:
- TICK_DIV, 50000000, clk cycles per second. Minimum 2; benches use 4.
- PRE_W, 26, prescaler counter width. Must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- set_btn  in  1  mode-cycle button; already debounced and synchronous to clk
- inc_btn  in  1  increment button; already debounced and synchronous to clk
- hr_bcd  out  8  hours, BCD 00-23; [7:4] tens, [3:0] units
- min_bcd  out  8  minutes, BCD 00-59
- sec_bcd  out  8  seconds, BCD 00-59
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 never driven
- sec_tick  out  1  one-cycle pulse, coincident with each RUN-mode seconds update
- min_tick  out  1  one-cycle pulse, coincident with each RUN-mode minute carry

Behaviour:
- Reset: hr/min/sec = 00, mode = RUN, prescaler = 0, sec_tick = min_tick = 0, both edge-detect registers = 0. Reset has priority over all other activity, including mid-set.
- Outputs:
  - All outputs are registered.
  - The BCD nibble of every output is always 0-9.
  - Tens digits: hr[7:4] ≤ 2, min/sec[7:4] ≤ 5.
- Edge detect:
  - set_rise = set_btn & ~set_q; inc_rise likewise from inc_q.
  - A held button acts exactly once.
- FSM:
  - set_rise advances RUN→SET_HR→SET_MIN→RUN.
  - The new mode is visible on the clock edge following the rise.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and then returns to 0.
  - On the edge where the prescaler leaves TICK_DIV-1, in the same edge:
    - seconds increment;
    - sec_tick = 1 for exactly that following cycle.
  - Tick period is TICK_DIV cycles. The first tick after reset appears TICK_DIV cycles after rst deasserts.
- Carry chain, all updated in the same clock edge:
  - sec units 9→0 carries into sec tens.
  - sec 59→00 carries into minutes and sets min_tick = 1.
  - min 59→00 carries into hours.
  - hr 23→00; no day output.
  - 23:59:59 + tick → 00:00:00, with sec_tick = min_tick = 1.
- inc_rise in RUN: ignored.
- SET_HR:
  - Prescaler is held at 0 and seconds freeze.
  - inc_rise increments hours mod 24 (09→10, 19→20, 23→00). Minutes unaffected.
  - No sec_tick or min_tick is generated.
- SET_MIN:
  - Prescaler is held at 0.
  - inc_rise increments minutes mod 60 (59→00) with no carry into hours, and clears seconds to 00.
  - No ticks are generated.
- Leaving SET_MIN→RUN:
  - Prescaler restarts at 0.
  - The first tick comes TICK_DIV cycles after mode reads RUN.
- Simultaneous events:
  - set_rise and inc_rise in the same cycle: set_rise wins; the increment is discarded.
  - set_rise in RUN in the same cycle the prescaler is at TICK_DIV-1: the mode change wins, the pending tick is discarded, and time does not advance.
  - rst with any other input: reset result only.

Test Plan:
- Reset/count (TICK_DIV=4):
  - Stimulus: rst high 2 cycles, then low.
  - Required: sec_bcd 00→01 exactly 4 cycles after rst deasserts. sec_tick high 1 cycle per 4; 60 ticks give min_bcd 01, sec_bcd 00, one min_tick.
- Full wrap:
  - Stimulus: set 23:59 via the buttons, return to RUN, advance 59 ticks, then one more tick.
  - Required: after 59 ticks, 23:59:59. After the next tick, hr/min/sec = 00:00:00 with sec_tick and min_tick both high in that cycle.
- Set mode:
  - Stimulus: one set_btn pulse; 25 inc pulses; one set pulse; 61 inc pulses; one set pulse.
  - Required:
    - mode sequence 01, then 10, then 00.
    - hr_bcd reads 01 after the hour increments.
    - min_bcd reads 01 after the minute increments; hr unchanged.
    - sec_bcd = 00 after the first inc in SET_MIN.
    - No ticks while in the set modes.
- Held button:
  - Stimulus: inc_btn held high 50 cycles in SET_HR starting from hr 05.
  - Required: hr_bcd = 06; exactly one increment.
- Collisions:
  - Stimulus 1: set_btn and inc_btn rise together in SET_HR.
  - Required 1: mode → SET_MIN; hr unchanged.
  - Stimulus 2: set_btn rises in RUN while the prescaler is at 3.
  - Required 2: no sec_tick; seconds unchanged; mode → 01.
- Reset mid-set:
  - Stimulus: in SET_MIN at 14:37, assert rst for 1 cycle.
  - Required: mode 00, time 00:00:00, counting restarts, first tick after 4 cycles.
